// File: rtl/epd_pkg.sv
// ----------------------------------------------------------------------------
// epd_pkg
// Shared definitions for the Ethernet packet detector header-capture slice:
//   - epd_state_e : capture FSM states
//   - byte offsets of the preamble/SFD, destination, source and type fields
//   - epd_hdr_t   : packed header record stored in the header FIFO
//   - field_last  : index of the last byte of a field
// The record length field is 16 bits wide so the top-level LEN_W parameter
// may be set anywhere up to 16 without touching this package.
// ----------------------------------------------------------------------------
package epd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRE     = 3'd1,
        DST     = 3'd2,
        SRC     = 3'd3,
        TYPE    = 3'd4,
        PAYLOAD = 3'd5
    } epd_state_e;

    // Field lengths and the first payload byte index, all in frame bytes.
    localparam logic [4:0] PRE_LEN  = 5'd8;
    localparam logic [4:0] DST_LEN  = 5'd6;
    localparam logic [4:0] SRC_LEN  = 5'd6;
    localparam logic [4:0] TYPE_LEN = 5'd2;
    localparam logic [4:0] HDR_END  = 5'd22;

    localparam int REC_LEN_W = 16;

    typedef struct packed {
        logic [47:0]          dst;
        logic [47:0]          src;
        logic [15:0]          typ;
        logic [REC_LEN_W-1:0] len;
    } epd_hdr_t;

    // Byte index of the last byte of a field starting at 'start'.
    function automatic logic [4:0] field_last(input logic [4:0] start,
                                              input logic [4:0] len);
        return start + len - 5'd1;
    endfunction

endpackage

// File: rtl/epd_hdr_fifo.sv
// ----------------------------------------------------------------------------
// epd_hdr_fifo
// Synchronous header FIFO, DEPTH entries of epd_hdr_t (DEPTH a power of two).
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   push, wr_data  write request; accepted when not full, or when a pop
//                  happens in the same cycle (the freed slot is reused)
//   pop            read request; ignored while empty
//   rd_data        head entry (meaningful only while empty = 0)
//   full, empty    occupancy flags
// Pointers carry one extra wrap bit so full and empty can be told apart.
// ----------------------------------------------------------------------------
module epd_hdr_fifo
    import epd_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic     clock,
    input  logic     reset,
    input  logic     push,
    input  epd_hdr_t wr_data,
    input  logic     pop,
    output epd_hdr_t rd_data,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push_s;
    logic        do_pop_s;
    epd_hdr_t    mem_q [DEPTH];

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Qualify requests and compute next pointers.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push_s && !reset) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/epd_header_capture.sv
// ----------------------------------------------------------------------------
// epd_header_capture
// Follows the detector's byte stream, captures dst/src/type and the frame
// length, and at end of frame commits the header into a FIFO when the frame
// reached the payload and every detector flag is high.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   data, control         frame byte stream (control high = byte present)
//   *_valid (5 inputs)    detector field flags, sampled in the commit cycle
//   hdr_valid/hdr_ready   consumer handshake on the FIFO head
//   hdr_dst/src/type/len  head header; hold the last popped entry when empty
//   hdr_drop              one-cycle pulse when a good frame hit a full FIFO
//   drop_count            saturating drop counter, only with
//                         EPD_HDR_DROP_CNT_EN defined
// ----------------------------------------------------------------------------
module epd_header_capture
    import epd_pkg::*;
#(
    parameter int HDR_DEPTH = 4,
    parameter int LEN_W     = 11
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       data,
    input  logic             control,
    input  logic             preamble_valid,
    input  logic             dst_addr_valid,
    input  logic             src_addr_valid,
    input  logic             type_length_valid,
    input  logic             packet_size_valid,
    output logic             hdr_valid,
    input  logic             hdr_ready,
    output logic [47:0]      hdr_dst,
    output logic [47:0]      hdr_src,
    output logic [15:0]      hdr_type,
    output logic [LEN_W-1:0] hdr_len,
    output logic             hdr_drop
`ifdef EPD_HDR_DROP_CNT_EN
    ,
    output logic [3:0]       drop_count
`endif
);

    localparam logic [4:0] PRE_LAST  = field_last(5'd0, PRE_LEN);
    localparam logic [4:0] DST_LAST  = field_last(PRE_LEN, DST_LEN);
    localparam logic [4:0] SRC_LAST  = field_last(PRE_LEN + DST_LEN, SRC_LEN);
    localparam logic [4:0] TYPE_LAST = field_last(HDR_END - TYPE_LEN, TYPE_LEN);

    localparam logic [LEN_W-1:0]     LEN_MAX   = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0]     LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [REC_LEN_W-1:0] LEN_MAX_R = REC_LEN_W'((1 << LEN_W) - 1);

    epd_state_e       state_q, state_d;
    logic [4:0]       k_q, k_d;
    logic [47:0]      dst_q, dst_d;
    logic [47:0]      src_q, src_d;
    logic [15:0]      type_q, type_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ctrl_prev_q, ctrl_prev_d;
    logic             drop_q, drop_d;
    epd_hdr_t         last_q, last_d;

    logic     flags_ok_s;
    logic     commit_s;
    logic     pop_s;
    logic     fifo_full_s;
    logic     fifo_empty_s;
    epd_hdr_t wr_rec_s;
    epd_hdr_t head_s;
    epd_hdr_t out_rec_s;

    // Record lengths never exceed LEN_MAX; clamping keeps every bit in use.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [REC_LEN_W-1:0] l);
        if (l > LEN_MAX_R) begin
            return LEN_MAX;
        end else begin
            return l[LEN_W-1:0];
        end
    endfunction

    assign flags_ok_s = preamble_valid & dst_addr_valid & src_addr_valid &
                        type_length_valid & packet_size_valid;

    // Capture FSM: byte index, field shift registers and length counter.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        dst_d       = dst_q;
        src_d       = src_q;
        type_d      = type_q;
        len_d       = len_q;
        ctrl_prev_d = control;
        commit_s    = 1'b0;
        if ((state_q != IDLE) && !control) begin
            // End of frame: only frames that got past the type field count.
            state_d  = IDLE;
            commit_s = (state_q == PAYLOAD) && flags_ok_s;
        end else begin
            if ((state_q != IDLE) && (state_q != PRE) && (len_q != LEN_MAX)) begin
                len_d = len_q + LEN_ONE;
            end else begin
                len_d = len_q;
            end
            case (state_q)
                IDLE: begin
                    // Start only on a rising edge so a frame cut by reset is skipped.
                    if (control && !ctrl_prev_q) begin
                        state_d = PRE;
                        k_d     = 5'd1;
                        len_d   = {LEN_W{1'b0}};
                    end else begin
                        state_d = IDLE;
                    end
                end
                PRE: begin
                    k_d = k_q + 5'd1;
                    if (k_q == PRE_LAST) begin
                        state_d = DST;
                    end else begin
                        state_d = PRE;
                    end
                end
                DST: begin
                    k_d   = k_q + 5'd1;
                    dst_d = {dst_q[39:0], data};
                    if (k_q == DST_LAST) begin
                        state_d = SRC;
                    end else begin
                        state_d = DST;
                    end
                end
                SRC: begin
                    k_d   = k_q + 5'd1;
                    src_d = {src_q[39:0], data};
                    if (k_q == SRC_LAST) begin
                        state_d = TYPE;
                    end else begin
                        state_d = SRC;
                    end
                end
                TYPE: begin
                    k_d    = k_q + 5'd1;
                    type_d = {type_q[7:0], data};
                    if (k_q == TYPE_LAST) begin
                        state_d = PAYLOAD;
                    end else begin
                        state_d = TYPE;
                    end
                end
                PAYLOAD: begin
                    state_d = PAYLOAD;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Commit record, drop detection and the held output copy.
    always_comb begin
        wr_rec_s                = '0;
        wr_rec_s.dst            = dst_q;
        wr_rec_s.src            = src_q;
        wr_rec_s.typ            = type_q;
        wr_rec_s.len[LEN_W-1:0] = len_q;
        pop_s  = hdr_ready & ~fifo_empty_s;
        drop_d = commit_s & fifo_full_s & ~pop_s;
        if (pop_s) begin
            last_d = head_s;
        end else begin
            last_d = last_q;
        end
        if (fifo_empty_s) begin
            out_rec_s = last_q;
        end else begin
            out_rec_s = head_s;
        end
    end

    // State and capture registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= 5'd0;
            dst_q       <= 48'd0;
            src_q       <= 48'd0;
            type_q      <= 16'd0;
            len_q       <= {LEN_W{1'b0}};
            ctrl_prev_q <= 1'b1;
            drop_q      <= 1'b0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            type_q      <= type_d;
            len_q       <= len_d;
            ctrl_prev_q <= ctrl_prev_d;
            drop_q      <= drop_d;
            last_q      <= last_d;
        end
    end

    epd_hdr_fifo #(
        .DEPTH (HDR_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (commit_s),
        .wr_data (wr_rec_s),
        .pop     (pop_s),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign hdr_valid = ~fifo_empty_s;
    assign hdr_dst   = out_rec_s.dst;
    assign hdr_src   = out_rec_s.src;
    assign hdr_type  = out_rec_s.typ;
    assign hdr_len   = clamp_len(out_rec_s.len);
    assign hdr_drop  = drop_q;

`ifdef EPD_HDR_DROP_CNT_EN
    logic [3:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of lost good frames.
    always_comb begin
        if (drop_d && (drop_cnt_q != 4'd15)) begin
            drop_cnt_d = drop_cnt_q + 4'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt_q <= 4'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_epd_header_capture.sv
module tb_epd_header_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  data;
    logic        control;
    logic        pv, dv, sv, tv, lv;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [47:0] hdr_dst;
    logic [47:0] hdr_src;
    logic [15:0] hdr_type;
    logic [10:0] hdr_len;
    logic        hdr_drop;
`ifdef EPD_HDR_DROP_CNT_EN
    logic [3:0]  drop_count;
`endif

    always #5 clock = ~clock;

    epd_header_capture #(.HDR_DEPTH(4), .LEN_W(11)) dut (
        .clock             (clock),
        .reset             (reset),
        .data              (data),
        .control           (control),
        .preamble_valid    (pv),
        .dst_addr_valid    (dv),
        .src_addr_valid    (sv),
        .type_length_valid (tv),
        .packet_size_valid (lv),
        .hdr_valid         (hdr_valid),
        .hdr_ready         (hdr_ready),
        .hdr_dst           (hdr_dst),
        .hdr_src           (hdr_src),
        .hdr_type          (hdr_type),
        .hdr_len           (hdr_len),
        .hdr_drop          (hdr_drop)
`ifdef EPD_HDR_DROP_CNT_EN
        ,
        .drop_count        (drop_count)
`endif
    );

    typedef struct packed {
        logic [47:0] d;
        logic [47:0] s;
        logic [15:0] t;
        logic [10:0] l;
    } exp_t;

    int   n_checks = 0;
    int   n_err    = 0;
    int   drop_seen = 0;
    bit   chk_en   = 1'b0;

    // Transaction-level model: frames collected as byte lists, expected
    // headers kept in a queue of at most 4.
    exp_t         m_q[$];
    exp_t         m_last = '0;
    logic         m_drop = 1'b0;
    int           m_dcnt = 0;
    logic [7:0]   m_bytes[$];
    bit           m_in   = 1'b0;
    bit           m_prev = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after posedge, so at negedge they are what the next
    // edge will sample: check outputs against the model, then advance it.
    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            exp_t cur;
            exp_t e;
            bit   full_b, pop_b;
            int   n;
            if (m_q.size() > 0) cur = m_q[0];
            else                cur = m_last;
            check("valid", hdr_valid, (m_q.size() > 0));
            check("dst",   hdr_dst,   cur.d);
            check("src",   hdr_src,   cur.s);
            check("type",  hdr_type,  cur.t);
            check("len",   hdr_len,   cur.l);
            check("drop",  hdr_drop,  m_drop);
`ifdef EPD_HDR_DROP_CNT_EN
            check("dcnt",  drop_count, m_dcnt[3:0]);
`endif
            if (hdr_drop === 1'b1) drop_seen++;

            if (reset) begin
                m_q.delete();
                m_bytes.delete();
                m_in   = 1'b0;
                m_prev = 1'b1;
                m_drop = 1'b0;
                m_last = '0;
                m_dcnt = 0;
            end else begin
                m_drop = 1'b0;
                full_b = (m_q.size() == 4);
                pop_b  = (m_q.size() > 0) && hdr_ready;
                if (pop_b) begin
                    m_last = m_q[0];
                    void'(m_q.pop_front());
                end
                if (m_in && !control) begin
                    m_in = 1'b0;
                    if (m_bytes.size() >= 22 && {pv, dv, sv, tv, lv} == 5'b11111) begin
                        e = '0;
                        for (int i = 0; i < 6; i++) begin
                            e.d = {e.d[39:0], m_bytes[8 + i]};
                            e.s = {e.s[39:0], m_bytes[14 + i]};
                        end
                        e.t = {m_bytes[20], m_bytes[21]};
                        n   = m_bytes.size() - 8;
                        e.l = (n > 2047) ? 11'd2047 : 11'(n);
                        if (!full_b || pop_b) begin
                            m_q.push_back(e);
                        end else begin
                            m_drop = 1'b1;
                            if (m_dcnt < 15) m_dcnt++;
                        end
                    end
                end else if (m_in) begin
                    m_bytes.push_back(data);
                end else if (control && !m_prev) begin
                    m_in = 1'b1;
                    m_bytes.delete();
                    m_bytes.push_back(data);
                end
                m_prev = control;
            end
        end
    end

    // Drives one frame; returns just after the edge that opens commit cycle C.
    task automatic send_frame(input logic [47:0] d, input logic [47:0] s,
                              input logic [15:0] t, input int npay, input int limit,
                              input logic [4:0] fl, input logic rdy_c);
        logic [7:0] fb[$];
        int         n;
        for (int i = 0; i < 7; i++) fb.push_back(8'h55);
        fb.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) fb.push_back(d[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) fb.push_back(s[i*8 +: 8]);
        fb.push_back(t[15:8]);
        fb.push_back(t[7:0]);
        for (int i = 0; i < npay; i++) fb.push_back(8'(i * 3 + 1));
        n = (limit >= 0 && limit < fb.size()) ? limit : fb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            control = 1'b1;
            data    = fb[i];
            if (i == 0) {pv, dv, sv, tv, lv} = fl;
        end
        @(posedge clock); #1;
        control   = 1'b0;
        data      = 8'h00;
        hdr_ready = rdy_c;
    endtask

    task automatic to_c1();
        @(negedge clock);
        @(negedge clock);
    endtask

    initial begin
        int n_pop;
        reset     = 1'b1;
        control   = 1'b0;
        data      = 8'h00;
        {pv, dv, sv, tv, lv} = 5'b00000;
        hdr_ready = 1'b0;
        @(posedge clock); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_valid", hdr_valid, 1'b0);
        check("rst_dst",   hdr_dst,   48'h0);
        check("rst_drop",  hdr_drop,  1'b0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Good frame
        hdr_ready = 1'b1;
        send_frame(48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800, 46, -1, 5'b11111, 1'b1);
        to_c1();
        check("good_valid", hdr_valid, 1'b1);
        check("good_dst",   hdr_dst,   48'h010203040506);
        check("good_src",   hdr_src,   48'h0A0B0C0D0E0F);
        check("good_type",  hdr_type,  16'h0800);
        check("good_len",   hdr_len,   11'd60);

        // Bad type/length flag
        send_frame(48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800, 46, -1, 5'b11101, 1'b1);
        to_c1();
        check("bad_valid", hdr_valid, 1'b0);
        check("bad_drop",  hdr_drop,  1'b0);

        // Short frame (15 bytes)
        send_frame(48'h111111111111, 48'h222222222222, 16'h1234, 46, 15, 5'b11111, 1'b1);
        to_c1();
        check("short_valid", hdr_valid, 1'b0);

        // Minimum frame immediately followed by a saturating long frame
        send_frame(48'hAABBCCDDEEFF, 48'h998877665544, 16'h86DD, 0, -1, 5'b11111, 1'b1);
        send_frame(48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, 16'h0042, 2100, -1, 5'b11111, 1'b1);
        to_c1();
        check("sat_valid", hdr_valid, 1'b1);
        check("sat_len",   hdr_len,   11'd2047);

        // Overflow: 5 frames, consumer stalled
        @(posedge clock); #1;
        hdr_ready = 1'b0;
        for (int i = 1; i <= 5; i++)
            send_frame({40'h0000000010, 8'(i)}, 48'h0000000000AA, 16'h0800, 46, -1, 5'b11111, 1'b0);
        to_c1();
        check("ovf_drop", hdr_drop, 1'b1);
        check("ovf_head", hdr_dst,  48'h000000001001);
`ifdef EPD_HDR_DROP_CNT_EN
        check("ovf_dcnt", drop_count, 4'd1);
`endif
        @(negedge clock);
        check("ovf_pulses", drop_seen, 1);

        // Full FIFO with a pop in the commit cycle
        send_frame({40'h0000000010, 8'd6}, 48'h0000000000AA, 16'h0800, 46, -1, 5'b11111, 1'b1);
        @(posedge clock); #1;
        hdr_ready = 1'b0;
        @(negedge clock);
        check("fp_drop", hdr_drop, 1'b0);
        check("fp_head", hdr_dst,  48'h000000001002);
        @(posedge clock); #1;
        hdr_ready = 1'b1;
        n_pop = 0;
        repeat (8) begin
            @(negedge clock);
            if (hdr_valid === 1'b1) n_pop++;
        end
        check("fp_drain", n_pop, 4);
        check("fp_pulses", drop_seen, 1);

        // Reset in the middle of a frame, with an entry already queued
        @(posedge clock); #1;
        hdr_ready = 1'b0;
        send_frame({40'h0000000010, 8'h20}, 48'h0000000000BB, 16'h0800, 46, -1, 5'b11111, 1'b0);
        for (int i = 0; i < 13; i++) begin
            @(posedge clock); #1;
            control = 1'b1;
            data    = (i < 7) ? 8'h55 : ((i == 7) ? 8'hD5 : 8'(i));
            if (i == 12) reset = 1'b1;
        end
        repeat (2) begin
            @(posedge clock); #1;
            data = 8'h77;
        end
        @(negedge clock);
        check("rmf_rst_valid", hdr_valid, 1'b0);
        check("rmf_rst_dst",   hdr_dst,   48'h0);
        check("rmf_rst_drop",  hdr_drop,  1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            data = 8'(8'h30 + i);
        end
        @(posedge clock); #1;
        control = 1'b0;
        hdr_ready = 1'b1;
        send_frame(48'h0102030405FF, 48'h0A0B0C0D0E0F, 16'h0806, 46, -1, 5'b11111, 1'b1);
        to_c1();
        check("rmf_valid", hdr_valid, 1'b1);
        check("rmf_dst",   hdr_dst,   48'h0102030405FF);
        check("rmf_type",  hdr_type,  16'h0806);
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("end_valid", hdr_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
